bus_ram_responder: RTL and testbench
====================================

# bus_ram_responder

Memory-bus responder serving the single-outstanding word-read and word-write bus that the instruction and data caches drive as initiators. It owns a word-addressed on-chip RAM and answers each accepted request with a one-cycle `bus_ready` pulse after a fixed, parameterised latency. On reads, that pulse carries the read data. It is the default backing store for simulation and FPGA builds without external memory.

## Interface
- `ADDR_BITS`, 12: RAM depth is 2^ADDR_BITS 32-bit words; upper address bits are ignored, so addresses alias.
- `LATENCY`, 2: number of cycles from the request-accept cycle to the `bus_ready` cycle; legal range 1..15.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low.
- `bus_rd`  in  1  read request level; the initiator holds it until it samples `bus_ready`.
- `bus_wr`  in  1  write request level; same hold rule as `bus_rd`.
- `bus_address`  in  32  word address; bits [ADDR_BITS-1:0] are used.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data; valid only while `bus_ready`=1 for a read, otherwise 0.
- `bus_ready`  out  1  one-cycle completion pulse for both reads and writes.
- `busy`  out  1  high from the accept cycle through the `bus_ready` cycle.

## Operation
- **Reset values:** `bus_ready`=0, `bus_rdata`=0, `busy`=0, state=IDLE, latency counter=0. RAM contents are not cleared.
- **States:** IDLE, WAIT, RESP.
- **IDLE**
  - If `bus_wr`=1: capture address and wdata, write the RAM at this edge, and set kind=WRITE.
  - Else if `bus_rd`=1: capture the address and set kind=READ.
  - Write has priority when both requests are high. A read held high alongside it is accepted on a later IDLE cycle.
  - On accept: counter=LATENCY-1, `busy`=1. Go to RESP if LATENCY=1, else go to WAIT.
- **WAIT:** decrement the counter each cycle. When the counter reaches 1, register the RAM read for a READ and go to RESP.
- **RESP:** `bus_ready`=1 for exactly this cycle. `bus_rdata` = RAM[captured address] for a READ, or 0 for a WRITE. Next state is IDLE.
- **No accept while responding:** the responder must not accept a request in the RESP cycle. The initiator drops its request on the edge that ends RESP, so a request is never double-served.
- **Captured values:** changes to `bus_address` or `bus_wdata` after accept are ignored.
- **Abort:** if the initiator drops `bus_rd` or `bus_wr` before `bus_ready`, the transaction still completes and the `bus_ready` pulse is still emitted. The initiator must tolerate a stray pulse. If the request is still high in the IDLE cycle after RESP, it is a new request.
- **Read-after-write:** a read accepted after a write's RESP returns the new data.
- **Reset mid-operation:** any pending transaction is dropped with no `bus_ready` pulse. A write already performed at its accept edge stays in RAM.

## Timing
- The request is sampled in cycle 0 (IDLE, request high). `bus_ready` is high in cycle LATENCY.
- Minimum request-to-request spacing is LATENCY+1 cycles.
- Back-to-back 16-word line fill with LATENCY=2 and the initiator re-raising `bus_rd` one cycle after ready:
  - one word every 4 cycles;
  - 64 cycles per line.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Reset values:** hold `reset`=0 for 3 cycles with `bus_rd`=1. Require `bus_ready`=0, `bus_rdata`=0 and `busy`=0 throughout. After release, the first `bus_ready` must appear LATENCY cycles after the first high sample.
- **Write then read:** with LATENCY=2, write 0xDEADBEEF to address 0x10, then read 0x10. The write gives `bus_ready` in cycle 2 with `bus_rdata`=0. The read gives `bus_ready` 2 cycles after its accept with `bus_rdata`=0xDEADBEEF.
- **Simultaneous read and write:** hold `bus_rd` and `bus_wr` high together at address 0x20 with wdata 0x1234. Require the write to be served first. The read served next must return 0x1234.
- **Line fill:** model the cache-style initiator filling words 0x100..0x10F, pre-loaded with value = address. Require 16 `bus_ready` pulses, each `bus_rdata` equal to its address, and no duplicate pulse.
- **Reset mid-transaction:** accept a read at LATENCY=4, then assert `reset` in cycle 2. Require no `bus_ready` pulse. After release, a new read of the same address completes in exactly 4 cycles.
- **Abort and aliasing:** drop `bus_rd` one cycle after accept and require one `bus_ready` pulse anyway. Read address 0x0000_1010 with ADDR_BITS=12 and require the data stored at 0x010.

Source files
------------

// File: rtl/bus_ram_responder_if.sv
// Single-outstanding word read/write bus between a cache initiator and the RAM responder.
// Requests are levels held until bus_ready; bus_ready, bus_rdata and busy come back from the responder.
interface bus_ram_responder_if;
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_address;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        busy;

    modport master (
        output bus_rd, bus_wr, bus_address, bus_wdata,
        input  bus_rdata, bus_ready, busy
    );

    modport slave (
        input  bus_rd, bus_wr, bus_address, bus_wdata,
        output bus_rdata, bus_ready, busy
    );
endinterface

// File: rtl/bus_ram_responder.sv
// Word-addressed RAM behind the cache bus; bus_ready pulses LATENCY cycles after accept.
// No accept outside IDLE, so requests spaced closer than LATENCY+1 cycles simply wait.
module bus_ram_responder #(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    bus_ram_responder_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);

    logic [31:0]          mem [0:(1 << ADDR_BITS) - 1];
    logic [1:0]           state;
    logic [3:0]           cnt;
    logic                 kind_rd;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 ready_q;
    logic                 busy_q;
    logic [31:0]          rdata_q;

    logic                 accept_wr;
    logic                 accept_rd;
    logic [ADDR_BITS-1:0] req_addr;
    logic                 unused_addr_bits;

    // Write wins when both levels are high; the read stays pending for a later IDLE cycle.
    assign accept_wr        = (state == ST_IDLE) && bus.bus_wr;
    assign accept_rd        = (state == ST_IDLE) && !bus.bus_wr && bus.bus_rd;
    assign req_addr         = bus.bus_address[ADDR_BITS-1:0];
    assign unused_addr_bits = ^bus.bus_address[31:ADDR_BITS];

    // The write lands in RAM on the accept edge, so it survives a later reset.
    always_ff @(posedge clk) begin
        if (reset && accept_wr) begin
            mem[req_addr] <= bus.bus_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            kind_rd <= 1'b0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            case (state)
                ST_IDLE: begin
                    if (accept_wr || accept_rd) begin
                        addr_q  <= req_addr;
                        kind_rd <= accept_rd;
                        cnt     <= LAT_M1;
                        busy_q  <= 1'b1;
                        if (LATENCY == 1) begin
                            state   <= ST_RESP;
                            ready_q <= 1'b1;
                            if (accept_rd) begin
                                rdata_q <= mem[req_addr];
                            end
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd1) begin
                        state   <= ST_RESP;
                        cnt     <= 4'd0;
                        ready_q <= 1'b1;
                        if (kind_rd) begin
                            rdata_q <= mem[addr_q];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Never accept here: the initiator still holds the request until this edge.
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bus_ready = ready_q;
    assign bus.bus_rdata = rdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Drives three responders (LATENCY 1, 2, 4) with one shared stimulus stream.
// Each is checked every cycle against an accept-time/due-time model, plus per-cycle tables and directed sequences.
module tb_bus_ram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    bus_ram_responder_if b1 ();
    bus_ram_responder_if b2 ();
    bus_ram_responder_if b4 ();

    assign b1.bus_rd = rd;  assign b1.bus_wr = wr;  assign b1.bus_address = addr;  assign b1.bus_wdata = wdata;
    assign b2.bus_rd = rd;  assign b2.bus_wr = wr;  assign b2.bus_address = addr;  assign b2.bus_wdata = wdata;
    assign b4.bus_rd = rd;  assign b4.bus_wr = wr;  assign b4.bus_address = addr;  assign b4.bus_wdata = wdata;

    bus_ram_responder #(.ADDR_BITS(12), .LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(b1));
    bus_ram_responder #(.ADDR_BITS(12), .LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(b2));
    bus_ram_responder #(.ADDR_BITS(12), .LATENCY(4)) u_l4 (.clk(clk), .reset(reset), .bus(b4));

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a transaction accepted at edge a is busy for edges a..a+L-1,
    // pulses ready after edge a+L-1, and the next accept may happen at edge a+L+1.
    int          lat [3] = '{1, 2, 4};
    longint      ecnt = 0;
    longint      acc_e [3] = '{-100, -100, -100};
    longint      free_e [3] = '{0, 0, 0};
    logic        m_rd [3];
    logic [11:0] m_addr [3];
    logic [31:0] mem_m [int];
    int          pulses2 = 0;

    typedef struct {
        logic        rst, rd, wr;
        logic [31:0] addr, wdata;
        logic        e_rdy, e_busy, chk_d;
        logic [31:0] e_dat;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(logic r, logic rdv, logic wrv, logic [31:0] a, logic [31:0] wd,
                                logic er, logic eb, logic cd, logic [31:0] ed);
        vec_t v;
        v.rst = r; v.rd = rdv; v.wr = wrv; v.addr = a; v.wdata = wd;
        v.e_rdy = er; v.e_busy = eb; v.chk_d = cd; v.e_dat = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, ecnt);
        end
    endtask

    task automatic step();
        logic        act_r [3];
        logic        act_b [3];
        logic [31:0] act_d [3];
        logic        exp_r, exp_b;
        int          key;
        @(posedge clk);
        ecnt++;
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                acc_e[i]  = -100;
                free_e[i] = ecnt + 1;
            end else if (ecnt >= free_e[i] && (rd || wr)) begin
                acc_e[i]  = ecnt;
                free_e[i] = ecnt + lat[i] + 1;
                m_rd[i]   = !wr;
                m_addr[i] = addr[11:0];
                if (wr) mem_m[i * 4096 + int'(addr[11:0])] = wdata;
            end
        end
        #1;
        act_r[0] = b1.bus_ready; act_b[0] = b1.busy; act_d[0] = b1.bus_rdata;
        act_r[1] = b2.bus_ready; act_b[1] = b2.busy; act_d[1] = b2.bus_rdata;
        act_r[2] = b4.bus_ready; act_b[2] = b4.busy; act_d[2] = b4.bus_rdata;
        for (int i = 0; i < 3; i++) begin
            exp_b = (acc_e[i] >= 0) && (ecnt >= acc_e[i]) && (ecnt <= acc_e[i] + lat[i] - 1);
            exp_r = (acc_e[i] >= 0) && (ecnt == acc_e[i] + lat[i] - 1);
            chk($sformatf("model busy L%0d", lat[i]), 32'(act_b[i]), 32'(exp_b));
            chk($sformatf("model ready L%0d", lat[i]), 32'(act_r[i]), 32'(exp_r));
            key = i * 4096 + int'(m_addr[i]);
            if (exp_r && m_rd[i]) begin
                if (mem_m.exists(key)) chk($sformatf("model rdata L%0d", lat[i]), act_d[i], mem_m[key]);
            end else begin
                chk($sformatf("model rdata idle L%0d", lat[i]), act_d[i], 32'd0);
            end
        end
        if (act_r[1]) pulses2++;
    endtask

    // Cache-style initiator paced by the LATENCY=2 responder: hold until ready, drop after the ready cycle.
    task automatic xfer(input logic is_wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdat, output int ncyc);
        logic got;
        got = 1'b0; rdat = 32'd0; ncyc = 0;
        rd = !is_wr; wr = is_wr; addr = a; wdata = wd;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            ncyc++;
            if (b2.bus_ready) begin
                got  = 1'b1;
                rdat = b2.bus_rdata;
            end
        end
        chk("xfer got ready", 32'(got), 32'd1);
        step();
        ncyc++;
        rd = 1'b0; wr = 1'b0;
    endtask

    initial begin
        logic [31:0] rdat;
        int          n, total, seen;
        logic        got;

        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;

        // Expected columns are for the LATENCY=2 responder.
        tbl[0]  = mk(0, 1, 0, 32'h10,   32'h0,        0, 0, 1, 32'h0);
        tbl[1]  = mk(0, 1, 0, 32'h10,   32'h0,        0, 0, 1, 32'h0);
        tbl[2]  = mk(0, 1, 0, 32'h10,   32'h0,        0, 0, 1, 32'h0);
        tbl[3]  = mk(1, 1, 0, 32'h10,   32'h0,        0, 1, 1, 32'h0);
        tbl[4]  = mk(1, 1, 0, 32'h10,   32'h0,        1, 1, 0, 32'h0);
        tbl[5]  = mk(1, 1, 0, 32'h10,   32'h0,        0, 0, 1, 32'h0);
        tbl[6]  = mk(1, 0, 1, 32'h10,   32'hDEADBEEF, 0, 1, 1, 32'h0);
        tbl[7]  = mk(1, 0, 1, 32'h10,   32'hDEADBEEF, 1, 1, 1, 32'h0);
        tbl[8]  = mk(1, 0, 1, 32'h10,   32'hDEADBEEF, 0, 0, 1, 32'h0);
        tbl[9]  = mk(1, 1, 0, 32'h10,   32'h0,        0, 1, 1, 32'h0);
        tbl[10] = mk(1, 1, 0, 32'h55,   32'h0,        1, 1, 1, 32'hDEADBEEF);
        tbl[11] = mk(1, 1, 0, 32'h55,   32'h0,        0, 0, 1, 32'h0);
        tbl[12] = mk(1, 0, 0, 32'h0,    32'h0,        0, 0, 1, 32'h0);
        tbl[13] = mk(1, 1, 1, 32'h20,   32'h1234,     0, 1, 1, 32'h0);
        tbl[14] = mk(1, 1, 1, 32'h20,   32'h1234,     1, 1, 1, 32'h0);
        tbl[15] = mk(1, 1, 1, 32'h20,   32'h1234,     0, 0, 1, 32'h0);
        tbl[16] = mk(1, 1, 0, 32'h20,   32'h0,        0, 1, 1, 32'h0);
        tbl[17] = mk(1, 1, 0, 32'h20,   32'h0,        1, 1, 1, 32'h1234);
        tbl[18] = mk(1, 1, 0, 32'h20,   32'h0,        0, 0, 1, 32'h0);
        tbl[19] = mk(1, 0, 0, 32'h0,    32'h0,        0, 0, 1, 32'h0);
        tbl[20] = mk(1, 1, 0, 32'h1010, 32'h0,        0, 1, 1, 32'h0);
        tbl[21] = mk(1, 0, 0, 32'h1010, 32'h0,        1, 1, 1, 32'hDEADBEEF);
        tbl[22] = mk(1, 0, 0, 32'h0,    32'h0,        0, 0, 1, 32'h0);

        for (int r = 0; r < 23; r++) begin
            reset = tbl[r].rst; rd = tbl[r].rd; wr = tbl[r].wr;
            addr = tbl[r].addr; wdata = tbl[r].wdata;
            step();
            chk($sformatf("tbl%0d ready", r), 32'(b2.bus_ready), 32'(tbl[r].e_rdy));
            chk($sformatf("tbl%0d busy", r), 32'(b2.busy), 32'(tbl[r].e_busy));
            if (tbl[r].chk_d) chk($sformatf("tbl%0d rdata", r), b2.bus_rdata, tbl[r].e_dat);
        end
        rd = 1'b0; wr = 1'b0;
        repeat (6) step();

        // Line fill of 0x100..0x10F, preloaded with value = address.
        for (int w = 0; w < 16; w++) begin
            xfer(1'b1, 32'h100 + 32'(w), 32'h100 + 32'(w), rdat, n);
            step();
        end
        pulses2 = 0;
        total = 0;
        for (int w = 0; w < 16; w++) begin
            xfer(1'b0, 32'h100 + 32'(w), 32'h0, rdat, n);
            chk($sformatf("fill word %0d", w), rdat, 32'h100 + 32'(w));
            step();
            total += n + 1;
        end
        chk("fill pulses", 32'(pulses2), 32'd16);
        chk("fill cycles", 32'(total), 32'd64);
        repeat (6) step();

        // Reset during a LATENCY=4 read: no pulse, then a clean 4-cycle read.
        wr = 1'b1; addr = 32'h40; wdata = 32'hCAFE0040;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            got = b4.bus_ready;
        end
        step();
        wr = 1'b0;
        step();
        rd = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1; rd = 1'b0;
        seen = 0;
        repeat (6) begin
            step();
            if (b4.bus_ready) seen++;
        end
        chk("L4 pulse after reset", 32'(seen), 32'd0);
        rd = 1'b1;
        n = 0; got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            n++;
            if (b4.bus_ready) begin
                got = 1'b1;
                chk("L4 reread data", b4.bus_rdata, 32'hCAFE0040);
            end
        end
        chk("L4 reread cycles", 32'(n), 32'd4);
        step();
        rd = 1'b0;
        repeat (6) step();

        // Random open-loop traffic, including aliased upper address bits and stray resets.
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 59) != 0);
            rd    = 1'($urandom_range(0, 1));
            wr    = ($urandom_range(0, 3) == 0);
            addr  = ($urandom & 32'hFFFF_F000) | (32'h200 + 32'($urandom_range(0, 7)));
            wdata = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
